// File: rtl/power_stream_pkg.sv
// Shared types and defaults for the power stream driver and its vector buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package power_stream_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_RES_WIDTH  = 64;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_GAP_W      = 4;
    localparam int DEF_TIMEOUT    = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so a full-buffer run length (== depth) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/power_vec_buf.sv
// Vector storage for the stream driver: DEPTH x DATA_WIDTH register array.
// Latency: write lands at the clock edge; read is combinational by address.
// Backpressure: none; the caller gates writes.
module power_vec_buf
    import power_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/power_stream_driver.sv
// Streams len buffered vectors to the power block, one per beat with an optional idle gap, and counts results.
// Latency: start accepted at edge N -> first beat valid in cycle N+1; last beat at N+len+(len-1)*gap.
// Backpressure: none on the beat side; completion waits for len results or TIMEOUT idle cycles.
module power_stream_driver
    import power_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RES_WIDTH  = DEF_RES_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int GAP_W      = DEF_GAP_W,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0]    i_wr_data,
    input  logic                     i_start,
    input  logic [$clog2(DEPTH):0]   i_len,
    input  logic [GAP_W-1:0]         i_gap,
    output logic                     o_valid,
    output logic [DATA_WIDTH-1:0]    o_data,
    input  logic                     i_res_valid,
    input  logic [RES_WIDTH-1:0]     i_res_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_timeout,
    output logic [$clog2(DEPTH):0]   o_sent_cnt,
    output logic [$clog2(DEPTH):0]   o_recv_cnt,
    output logic [RES_WIDTH-1:0]     o_last_res
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    state_t state, state_nxt;

    logic [PTR_W-1:0]      ptr, ld_addr;
    logic [CNT_W-1:0]      len_q, len_in;
    logic [GAP_W-1:0]      gap_q, gap_cnt;
    logic [TO_W-1:0]       idle_cnt;
    logic [DATA_WIDTH-1:0] rd_data, ld_data;
    logic                  accept, wr_fire, load, to_hit, res_ok;

    assign accept  = (state == ST_IDLE) && i_start;
    assign wr_fire = (state == ST_IDLE) && i_wr_en;
    assign len_in  = (i_len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : i_len;
    assign ld_addr = (state == ST_IDLE) ? '0 : ptr;
    assign res_ok  = i_res_valid &&
                     ((state == ST_SEND) || (state == ST_GAP) || (state == ST_DRAIN));

    // A write landing on the same edge as the start must be seen by beat 0.
    assign ld_data = (wr_fire && (i_wr_addr == ld_addr)) ? i_wr_data : rd_data;

    power_vec_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (i_wr_addr),
        .wr_data (i_wr_data),
        .rd_addr (ld_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        to_hit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    if (len_in == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_SEND;
                        load      = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                // o_sent_cnt already includes the beat on the wire this cycle.
                if (o_sent_cnt == len_q) begin
                    state_nxt = ST_DRAIN;
                end else if (gap_q != '0) begin
                    state_nxt = ST_GAP;
                end else begin
                    load = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(1)) begin
                    state_nxt = ST_SEND;
                    load      = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (o_recv_cnt == len_q) begin
                    state_nxt = ST_DONE;
                end else if (!i_res_valid && (idle_cnt == TO_W'(TIMEOUT - 1))) begin
                    state_nxt = ST_DONE;
                    to_hit    = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            len_q      <= '0;
            gap_q      <= '0;
            gap_cnt    <= '0;
            idle_cnt   <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_timeout  <= 1'b0;
            o_sent_cnt <= '0;
            o_recv_cnt <= '0;
            o_last_res <= '0;
        end else begin
            state   <= state_nxt;
            o_busy  <= (state_nxt != ST_IDLE);
            o_done  <= (state_nxt == ST_DONE);
            o_valid <= load;
            o_data  <= load ? ld_data : '0;

            if (load) begin
                ptr <= ld_addr + PTR_W'(1);
            end

            if (accept) begin
                len_q      <= len_in;
                gap_q      <= i_gap;
                o_sent_cnt <= load ? CNT_W'(1) : '0;
            end else if (load) begin
                o_sent_cnt <= o_sent_cnt + CNT_W'(1);
            end

            if (accept) begin
                o_timeout <= 1'b0;
            end else if (to_hit) begin
                o_timeout <= 1'b1;
            end

            if ((state == ST_SEND) && (state_nxt == ST_GAP)) begin
                gap_cnt <= gap_q;
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end

            if ((state != ST_DRAIN) || i_res_valid) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TO_W'(1);
            end

            if (accept) begin
                o_recv_cnt <= '0;
            end else if (res_ok && (o_recv_cnt != len_q)) begin
                o_recv_cnt <= o_recv_cnt + CNT_W'(1);
            end

            if (res_ok) begin
                o_last_res <= i_res_data;
            end
        end
    end

endmodule

// File: tb/tb_power_stream_driver.sv
// Scoreboarded bench for power_stream_driver with a fixed-latency result loopback.
// Latency: expected beat cycles derived from the start cycle, len and gap.
// Backpressure: result side is shaped by per-run response and injection limits.
module tb_power_stream_driver;

    localparam int DW    = 32;
    localparam int RW    = 64;
    localparam int DEPTH = 8;

    typedef struct {
        logic [DW-1:0] dat;
        int            cyc;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_wr_en;
    logic [2:0]    i_wr_addr;
    logic [DW-1:0] i_wr_data;
    logic          i_start;
    logic [3:0]    i_len;
    logic [3:0]    i_gap;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_res_valid = 1'b0;
    logic [RW-1:0] i_res_data  = '0;
    logic          o_busy, o_done, o_timeout;
    logic [3:0]    o_sent_cnt, o_recv_cnt;
    logic [RW-1:0] o_last_res;

    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    int            resp_limit = 0;
    int            inj_limit = 0;
    int            c0;
    int            dcyc;
    beat_t         exp_q[$];
    logic [DW-1:0] tb_mem [DEPTH];

    power_stream_driver dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_wr_en     (i_wr_en),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .i_start     (i_start),
        .i_len       (i_len),
        .i_gap       (i_gap),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .i_res_valid (i_res_valid),
        .i_res_data  (i_res_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_timeout   (o_timeout),
        .o_sent_cnt  (o_sent_cnt),
        .o_recv_cnt  (o_recv_cnt),
        .o_last_res  (o_last_res)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [RW-1:0] sq(input logic [DW-1:0] x);
        return {32'b0, x} * {32'b0, x};
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Beat monitor plus result loopback (one result per beat, up to resp_limit;
    // extra results injected in the first gap, up to inj_limit).
    always @(negedge clk) begin
        beat_t e;
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexp_beat", o_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("beat_dat", o_data, e.dat);
                chk("beat_cyc", cyc, e.cyc);
            end
        end else if (o_busy) begin
            chk("idle_dat", o_data, 0);
        end
        i_res_valid = 1'b0;
        if (o_valid && (int'(o_sent_cnt) <= resp_limit)) begin
            i_res_valid = 1'b1;
            i_res_data  = sq(o_data);
        end else if (!o_valid && o_busy && (o_sent_cnt == 4'd1) &&
                     (int'(o_recv_cnt) < 1 + inj_limit)) begin
            i_res_valid = 1'b1;
            i_res_data  = 64'hE000 + RW'(o_recv_cnt);
        end
    end

    task automatic write_buf(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        i_wr_en   = 1'b1;
        i_wr_addr = a[2:0];
        i_wr_data = d;
        tb_mem[a] = d;
        @(negedge clk);
        i_wr_en = 1'b0;
    endtask

    task automatic start_run(input int len, input int gap, input bit do_wr, input logic [DW-1:0] wd);
        int n;
        @(negedge clk);
        i_start = 1'b1;
        i_len   = len[3:0];
        i_gap   = gap[3:0];
        if (do_wr) begin
            i_wr_en   = 1'b1;
            i_wr_addr = 3'd0;
            i_wr_data = wd;
            tb_mem[0] = wd;
        end
        c0 = cyc;
        n  = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.dat = tb_mem[i];
            b.cyc = c0 + 1 + i * (gap + 1);
            exp_q.push_back(b);
        end
        @(negedge clk);
        i_start = 1'b0;
        i_wr_en = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int d);
        d = -1;
        for (int i = 0; i < budget; i++) begin
            if (o_done) begin
                d = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", o_done, 1);
        chk("busy_in_done", o_busy, 1);
    endtask

    task automatic after_done();
        @(negedge clk);
        chk("done_pulse", o_done, 0);
        chk("idle_busy", o_busy, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        i_wr_en   = 1'b0;
        i_wr_addr = '0;
        i_wr_data = '0;
        i_start   = 1'b0;
        i_len     = '0;
        i_gap     = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_timeout", o_timeout, 0);
        chk("rst_sent", o_sent_cnt, 0);
        chk("rst_recv", o_recv_cnt, 0);
        chk("rst_last", o_last_res, 0);
        reset_n = 1'b1;

        write_buf(0, 32'h2);  write_buf(1, 32'h3);  write_buf(2, 32'h5);  write_buf(3, 32'h7);
        write_buf(4, 32'hA);  write_buf(5, 32'h11); write_buf(6, 32'h13); write_buf(7, 32'h17);

        // back-to-back, len=5
        resp_limit = 8;
        start_run(5, 0, 0, '0);
        wait_done(100, dcyc);
        chk("b2b_done_cyc", dcyc, c0 + 7);
        chk("b2b_sent", o_sent_cnt, 5);
        chk("b2b_recv", o_recv_cnt, 5);
        chk("b2b_last", o_last_res, sq(32'hA));
        chk("b2b_timeout", o_timeout, 0);
        after_done();

        // gapped, gap=2: last beat at start+13 is checked by the monitor
        start_run(5, 2, 0, '0);
        wait_done(100, dcyc);
        chk("gap_sent", o_sent_cnt, 5);
        chk("gap_recv", o_recv_cnt, 5);
        chk("gap_last", o_last_res, sq(32'hA));
        after_done();

        // timeout: only two results come back
        resp_limit = 2;
        start_run(3, 0, 0, '0);
        wait_done(200, dcyc);
        chk("to_done_cyc", dcyc, c0 + 68);
        chk("to_flag", o_timeout, 1);
        chk("to_recv", o_recv_cnt, 2);
        chk("to_sent", o_sent_cnt, 3);
        chk("to_last", o_last_res, sq(tb_mem[1]));
        after_done();
        repeat (3) @(negedge clk);
        chk("to_sticky", o_timeout, 1);
        resp_limit = 8;

        // len=0: done the cycle after start, no beats, timeout cleared
        start_run(0, 0, 0, '0);
        wait_done(20, dcyc);
        chk("len0_done_cyc", dcyc, c0 + 1);
        chk("len0_sent", o_sent_cnt, 0);
        chk("len0_timeout_clr", o_timeout, 0);
        after_done();

        // len=12 clamps to 8
        start_run(12, 0, 0, '0);
        wait_done(100, dcyc);
        chk("clamp_sent", o_sent_cnt, 8);
        chk("clamp_recv", o_recv_cnt, 8);
        chk("clamp_last", o_last_res, sq(tb_mem[7]));
        after_done();

        // start and write while busy are both dropped
        start_run(4, 3, 0, '0);
        repeat (2) @(negedge clk);
        i_start   = 1'b1;
        i_len     = 4'd2;
        i_gap     = 4'd0;
        i_wr_en   = 1'b1;
        i_wr_addr = 3'd0;
        i_wr_data = 32'hBAD;
        @(negedge clk);
        i_start = 1'b0;
        i_wr_en = 1'b0;
        wait_done(100, dcyc);
        chk("busy_sent", o_sent_cnt, 4);
        chk("busy_recv", o_recv_cnt, 4);
        after_done();
        start_run(1, 0, 0, '0);
        wait_done(100, dcyc);
        chk("busy_wr_dropped", o_last_res, sq(32'h2));
        after_done();

        // write and start on the same edge: beat 0 carries the new value
        start_run(2, 1, 1, 32'h55);
        wait_done(100, dcyc);
        chk("samecyc_last", o_last_res, sq(tb_mem[1]));
        chk("samecyc_sent", o_sent_cnt, 2);
        after_done();

        // extra results saturate the receive count
        inj_limit = 2;
        start_run(3, 3, 0, '0);
        wait_done(100, dcyc);
        chk("extra_recv", o_recv_cnt, 3);
        chk("extra_last", o_last_res, sq(tb_mem[2]));
        after_done();
        inj_limit = 0;

        // reset during the third beat
        start_run(5, 1, 0, '0);
        for (int i = 0; i < 50; i++) begin
            if (o_valid && (o_sent_cnt == 4'd3)) break;
            @(negedge clk);
        end
        chk("rst_mid_reach", o_sent_cnt, 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", o_valid, 0);
        chk("rst_mid_data", o_data, 0);
        chk("rst_mid_busy", o_busy, 0);
        chk("rst_mid_sent", o_sent_cnt, 0);
        chk("rst_mid_recv", o_recv_cnt, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        start_run(3, 0, 0, '0);
        wait_done(100, dcyc);
        chk("post_rst_sent", o_sent_cnt, 3);
        chk("post_rst_recv", o_recv_cnt, 3);
        chk("post_rst_last", o_last_res, sq(tb_mem[2]));
        after_done();

        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got no end expected end");
        $fatal(1);
    end

endmodule
